// File: rtl/rom_16x4.sv
// rom_16x4: 16-word x 4-bit read-only memory with a registered, enable-gated read port.
// Define ROM_PARITY_EN to add the registered even-parity output dout_par.
module rom_16x4 #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
`ifdef ROM_PARITY_EN
  output logic              dout_par,
`endif
  output logic [DATA_W-1:0] dout
);

  generate
    if ((DATA_W != 4) || (ADDR_W != 4)) begin : g_bad_param
      $error("rom_16x4 supports only DATA_W=4 and ADDR_W=4");
    end
  endgenerate

  // Fixed contents; an address outside the table cannot occur with a 4-bit address.
  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    case (a)
      4'h0:    rom_word = 4'hA;
      4'h1:    rom_word = 4'h3;
      4'h2:    rom_word = 4'h7;
      4'h3:    rom_word = 4'hF;
      4'h4:    rom_word = 4'h0;
      4'h5:    rom_word = 4'hC;
      4'h6:    rom_word = 4'h5;
      4'h7:    rom_word = 4'h9;
      4'h8:    rom_word = 4'h1;
      4'h9:    rom_word = 4'hE;
      4'hA:    rom_word = 4'h6;
      4'hB:    rom_word = 4'h2;
      4'hC:    rom_word = 4'h8;
      4'hD:    rom_word = 4'hD;
      4'hE:    rom_word = 4'h4;
      4'hF:    rom_word = 4'hB;
      default: rom_word = 4'h0;
    endcase
  endfunction

  function automatic logic parity_even(input logic [DATA_W-1:0] w);
    parity_even = ^w;
  endfunction

  logic [DATA_W-1:0] dout_d, dout_q;

  // Next read word: load from the table when enabled, otherwise hold (addr ignored).
  always_comb begin
    dout_d = dout_q;
    if (en) begin
      dout_d = rom_word(addr);
    end else begin
      dout_d = dout_q;
    end
  end

  // Read data register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q <= {DATA_W{1'b0}};
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

`ifdef ROM_PARITY_EN
  logic par_d, par_q;

  // Parity tracks the word being loaded so it always matches dout.
  always_comb begin
    par_d = par_q;
    if (en) begin
      par_d = parity_even(dout_d);
    end else begin
      par_d = par_q;
    end
  end

  // Parity register, updated in the same cycle as dout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign dout_par = par_q;
`endif

endmodule

// File: tb/tb_rom_16x4.sv
// tb_rom_16x4: directed/random reads against a table-driven model, plus literal expectations.
module tb_rom_16x4;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] addr;
  logic [3:0] dout;
`ifdef ROM_PARITY_EN
  logic       dout_par;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  localparam logic [3:0] ROM_TBL [16] = '{4'hA, 4'h3, 4'h7, 4'hF, 4'h0, 4'hC, 4'h5, 4'h9,
                                          4'h1, 4'hE, 4'h6, 4'h2, 4'h8, 4'hD, 4'h4, 4'hB};
  logic [63:0] sweep_vec;
  logic [3:0]  model_q;

  rom_16x4 #(.DATA_W(4), .ADDR_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .addr     (addr),
`ifdef ROM_PARITY_EN
    .dout_par (dout_par),
`endif
    .dout     (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a read returns the table word one edge later, reset clears, en=0 holds.
  always @(posedge clk or negedge rst) begin
    if (!rst) model_q <= 4'h0;
    else if (en) model_q <= ROM_TBL[addr];
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_dout", dout, model_q);
`ifdef ROM_PARITY_EN
      check("model_par", {3'b000, dout_par}, {3'b000, ^model_q});
`endif
    end
  end

  // One cycle: drive now (posedge+2), then check just after the next edge.
  task automatic cyc(input logic e, input logic [3:0] a, input bit do_chk,
                     input logic [3:0] exp, input string name);
    en = e;
    addr = a;
    @(posedge clk);
    #1;
    if (do_chk) check(name, dout, exp);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] r;
    sweep_vec = 64'hA37F_0C59_1E62_8D4B;
    rst = 1'b1; en = 1'b0; addr = 4'h0;
    #1 rst = 1'b0;
    #2 cmp_en = 1'b1;
    check("reset_state", dout, 4'h0);
    // Reset dominates even with en=1.
    @(posedge clk); #2;
    cyc(1'b1, 4'h3, 1'b1, 4'h0, "reset_hold_en");
    cyc(1'b1, 4'hF, 1'b1, 4'h0, "reset_hold_en2");
    rst = 1'b1;

    // Full back-to-back sweep, checked against the literal vector.
    for (int i = 0; i < 16; i++) begin
      logic [3:0] exp_w;
      exp_w = sweep_vec[63 - 4*i -: 4];
      cyc(1'b1, 4'(i), 1'b1, exp_w, "sweep");
    end

    // Hold with en=0, including an unknown address.
    cyc(1'b1, 4'h3, 1'b1, 4'hF, "hold_load");
    cyc(1'b0, 4'h5, 1'b1, 4'hF, "hold1");
    cyc(1'b0, 4'h5, 1'b1, 4'hF, "hold2");
    cyc(1'b0, 4'h5, 1'b1, 4'hF, "hold3");
    cyc(1'b0, 4'bxxxx, 1'b1, 4'hF, "hold_x_addr");
    cyc(1'b1, 4'h5, 1'b1, 4'hC, "hold_release");
    cyc(1'b1, 4'h7, 1'b1, 4'h9, "after_hold");

    // Async reset mid-cycle while dout=F.
    cyc(1'b1, 4'h3, 1'b1, 4'hF, "pre_async");
    rst = 1'b0;
    #1 check("async_rst", dout, 4'h0);
    #1;
    cyc(1'b1, 4'h3, 1'b1, 4'h0, "async_stay1");
    cyc(1'b1, 4'h3, 1'b1, 4'h0, "async_stay2");
    rst = 1'b1;
    cyc(1'b1, 4'h3, 1'b1, 4'hF, "async_recover");

    // Reset between reads of addr 2 and addr 7.
    cyc(1'b1, 4'h2, 1'b1, 4'h7, "stream_a2");
    rst = 1'b0;
    cyc(1'b1, 4'h7, 1'b1, 4'h0, "stream_rst");
    rst = 1'b1;
    cyc(1'b1, 4'h7, 1'b1, 4'h9, "stream_a7");

    // Random reads against the table.
    for (int i = 0; i < 16; i++) begin
      r = 4'($urandom_range(0, 15));
      cyc(1'b1, r, 1'b1, ROM_TBL[r], "random");
    end

`ifdef ROM_PARITY_EN
    cyc(1'b1, 4'h0, 1'b1, 4'hA, "par_a0");
    check("par_a0_bit", {3'b000, dout_par}, 4'h0);
    cyc(1'b1, 4'h9, 1'b1, 4'hE, "par_a9");
    check("par_a9_bit", {3'b000, dout_par}, 4'h1);
    cyc(1'b0, 4'h0, 1'b1, 4'hE, "par_hold");
    check("par_hold_bit", {3'b000, dout_par}, 4'h1);
`endif

    en = 1'b0;
    @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
